user_id_readout: RTL and testbench

//  Next-generation user/project ID block: a wide, parametrised ID (multiple 32-bit words)

---
 rtl/user_id_readout_pkg.sv | 27 ++
 rtl/user_id_readout_tie_array.sv | 27 ++
 rtl/user_id_readout.sv | 188 ++++++++++++++++++
 tb/tb_user_id_readout.sv | 528 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/user_id_readout_pkg.sv
// Shared definitions for the user/project ID readout block.
//   WORD_W     : width of one readable ID word
//   id_state_t : capture/verify/ready sequencing states
//   clog2/max2 : elaboration-time sizing helpers
package user_id_readout_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        ST_CAPTURE = 2'd0,
        ST_VERIFY  = 2'd1,
        ST_READY   = 2'd2
    } id_state_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result = 0;
        for (int unsigned i = 1; i < value; i = i * 2) begin
            result++;
        end
        return result;
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/user_id_readout_tie_array.sv
// Via-programmed ID source: one tie-high/tie-low cell pair per ID bit, with
// the per-bit select fixed by USER_PROJECT_ID (1 -> tie-high, 0 -> tie-low).
// Ports:
//   live [ID_WIDTH-1:0] : live ID vector straight off the tie cells
//   VDD, VSS            : supply pins (USE_POWER_PINS builds only)
module user_id_readout_tie_array #(
    parameter int unsigned          ID_WIDTH        = 64,
    parameter logic [ID_WIDTH-1:0]  USER_PROJECT_ID = '0
) (
`ifdef USE_POWER_PINS
    inout  wire                 VDD,
    inout  wire                 VSS,
`endif
    output logic [ID_WIDTH-1:0] live
);

    // Each bit keeps both cells of its pair; only the select decides which
    // one drives the bit, so re-programming the ID is a via change only.
    for (genvar i = 0; i < ID_WIDTH; i++) begin : g_bit
        logic tie_hi;
        logic tie_lo;
        assign tie_hi  = 1'b1;
        assign tie_lo  = 1'b0;
        assign live[i] = USER_PROJECT_ID[i] ? tie_hi : tie_lo;
    end

endmodule

// File: rtl/user_id_readout.sv
// User/project ID readout. After reset the live tie vector is captured into a
// shadow register and re-checked; the shadow is then served over a word
// req/ack port and as an MSB-first serial stream.
// Ports:
//   clk, resetn          : clock, synchronous active-low reset
//   rd_req/rd_addr       : word read request (held until rd_ack) and word index
//   rd_ack/rd_data/rd_err: one-cycle ack, registered word, out-of-range flag
//   ser_start            : pulse to begin serial readout
//   ser_busy/ser_valid   : serial shift in progress / bit valid
//   ser_data/ser_done    : serial bit (MSB first) / last-bit marker
//   id_ready/id_fault    : capture+verify complete / persistent verify mismatch
//   mask_rev             : live word 0, unclocked, for legacy consumers
module user_id_readout
    import user_id_readout_pkg::*;
#(
    parameter int unsigned          ID_WIDTH        = 64,
    parameter logic [ID_WIDTH-1:0]  USER_PROJECT_ID = '0,
    parameter int unsigned          MAX_RETRY       = 3,
    localparam int unsigned         NUM_WORDS       = ID_WIDTH / WORD_W,
    localparam int unsigned         ADDR_W          = max2(1, clog2(NUM_WORDS))
) (
    input  logic              clk,
    input  logic              resetn,
`ifdef USE_POWER_PINS
    inout  wire               VDD,
    inout  wire               VSS,
`endif
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_err,
    input  logic              ser_start,
    output logic              ser_busy,
    output logic              ser_data,
    output logic              ser_valid,
    output logic              ser_done,
    output logic              id_ready,
    output logic              id_fault,
    output logic [WORD_W-1:0] mask_rev
);

    localparam int unsigned           CNT_W       = clog2(ID_WIDTH) + 1;
    localparam int unsigned           RETRY_W     = max2(1, clog2(MAX_RETRY + 1));
    localparam logic [CNT_W-1:0]      LAST_IDX    = CNT_W'(ID_WIDTH - 1);
    localparam logic [RETRY_W-1:0]    RETRY_LIMIT = RETRY_W'(MAX_RETRY);

    id_state_t            state;
    id_state_t            state_next;
    logic [ID_WIDTH-1:0]  live;
    logic [ID_WIDTH-1:0]  shadow;
    logic [RETRY_W-1:0]   retry;
    logic                 capture_en;
    logic                 verify_en;
    logic                 live_match;

    logic                 rd_accept;
    logic                 rd_in_range;
    logic [ID_WIDTH-1:0]  rd_shifted;

    logic                 ser_accept;
    logic                 ser_last;
    logic [CNT_W-1:0]     ser_cnt;
    logic [CNT_W-1:0]     ser_cnt_next;
    logic [CNT_W-1:0]     ser_idx;
    logic [ID_WIDTH-1:0]  ser_shifted;

    user_id_readout_tie_array #(
        .ID_WIDTH        (ID_WIDTH),
        .USER_PROJECT_ID (USER_PROJECT_ID)
    ) u_tie_array (
`ifdef USE_POWER_PINS
        .VDD  (VDD),
        .VSS  (VSS),
`endif
        .live (live)
    );

    assign mask_rev   = live[WORD_W-1:0];
    assign live_match = (live == shadow);

    // ---------------- capture/verify FSM ----------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= ST_CAPTURE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_CAPTURE: state_next = ST_VERIFY;
            ST_VERIFY: begin
                if (live_match || (retry == RETRY_LIMIT)) begin
                    state_next = ST_READY;
                end else begin
                    state_next = ST_CAPTURE;
                end
            end
            ST_READY:   state_next = ST_READY;
            default:    state_next = ST_CAPTURE;
        endcase
    end

    always_comb begin
        capture_en = (state == ST_CAPTURE);
        verify_en  = (state == ST_VERIFY);
        id_ready   = (state == ST_READY);
    end

    // Shadow, retry count and sticky fault.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            shadow   <= '0;
            retry    <= '0;
            id_fault <= 1'b0;
        end else begin
            if (capture_en) begin
                shadow <= live;
            end
            if (verify_en && !live_match) begin
                if (retry == RETRY_LIMIT) begin
                    id_fault <= 1'b1;
                end else begin
                    retry <= retry + 1'b1;
                end
            end
        end
    end

    // ---------------- word read port ----------------
    // Blocking on rd_ack keeps a held request from being accepted twice and
    // spaces back-to-back accepts at least two cycles apart.
    assign rd_accept   = rd_req && id_ready && !rd_ack;
    assign rd_in_range = (32'(rd_addr) < NUM_WORDS);
    assign rd_shifted  = shadow >> (32'(rd_addr) * WORD_W);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_ack  <= 1'b0;
            rd_err  <= 1'b0;
            rd_data <= '0;
        end else begin
            rd_ack <= rd_accept;
            rd_err <= rd_accept && !rd_in_range;
            if (rd_accept) begin
                rd_data <= rd_in_range ? rd_shifted[WORD_W-1:0] : '0;
            end
        end
    end

    // ---------------- serial shifter ----------------
    // Bits are picked out of the shadow by index rather than through a
    // separate shift copy; the counter stops at LAST_IDX and never wraps.
    assign ser_accept   = ser_start && id_ready && !ser_busy;
    assign ser_last     = (ser_cnt == LAST_IDX);
    assign ser_cnt_next = ser_cnt + 1'b1;
    assign ser_idx      = ser_accept ? LAST_IDX : (LAST_IDX - ser_cnt_next);
    assign ser_shifted  = shadow >> ser_idx;
    assign ser_valid    = ser_busy;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ser_busy <= 1'b0;
            ser_data <= 1'b0;
            ser_done <= 1'b0;
            ser_cnt  <= '0;
        end else if (ser_accept) begin
            ser_busy <= 1'b1;
            ser_data <= ser_shifted[0];
            ser_done <= 1'b0;
            ser_cnt  <= '0;
        end else if (ser_busy) begin
            if (ser_last) begin
                ser_busy <= 1'b0;
                ser_data <= 1'b0;
                ser_done <= 1'b0;
            end else begin
                ser_cnt  <= ser_cnt_next;
                ser_data <= ser_shifted[0];
                ser_done <= (ser_cnt_next == LAST_IDX);
            end
        end
    end

endmodule

// File: tb/tb_user_id_readout.sv
module tb_user_id_readout;

    localparam logic [63:0] ID_A = 64'hDEADBEEF_12345678;
    localparam logic [31:0] ID_B = 32'h0000_0001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;

    logic        rd_req, rd_ack, rd_err;
    logic [0:0]  rd_addr;
    logic [31:0] rd_data, mask_rev;
    logic        ser_start, ser_busy, ser_data, ser_valid, ser_done;
    logic        id_ready, id_fault;

    logic        rd_req_b, rd_ack_b, rd_err_b;
    logic [0:0]  rd_addr_b;
    logic [31:0] rd_data_b, mask_rev_b;
    logic        ser_start_b, ser_busy_b, ser_data_b, ser_valid_b, ser_done_b;
    logic        id_ready_b, id_fault_b;

    int checks   = 0;
    int failures = 0;

    logic [63:0] id_val;
    logic [31:0] id_b_val;
    logic [63:0] force_val;
    logic [32:0] rd_exp_q[$];
    logic        ser_exp_q[$];

    user_id_readout #(
        .ID_WIDTH        (64),
        .USER_PROJECT_ID (ID_A),
        .MAX_RETRY       (3)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_ack    (rd_ack),
        .rd_data   (rd_data),
        .rd_err    (rd_err),
        .ser_start (ser_start),
        .ser_busy  (ser_busy),
        .ser_data  (ser_data),
        .ser_valid (ser_valid),
        .ser_done  (ser_done),
        .id_ready  (id_ready),
        .id_fault  (id_fault),
        .mask_rev  (mask_rev)
    );

    user_id_readout #(
        .ID_WIDTH        (32),
        .USER_PROJECT_ID (ID_B),
        .MAX_RETRY       (3)
    ) dut_b (
        .clk       (clk),
        .resetn    (resetn),
        .rd_req    (rd_req_b),
        .rd_addr   (rd_addr_b),
        .rd_ack    (rd_ack_b),
        .rd_data   (rd_data_b),
        .rd_err    (rd_err_b),
        .ser_start (ser_start_b),
        .ser_busy  (ser_busy_b),
        .ser_data  (ser_data_b),
        .ser_valid (ser_valid_b),
        .ser_done  (ser_done_b),
        .id_ready  (id_ready_b),
        .id_fault  (id_fault_b),
        .mask_rev  (mask_rev_b)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reset state, with a word-1 request already held from reset.
    task automatic test_reset();
        resetn      = 1'b0;
        rd_req      = 1'b1;
        rd_addr     = 1'b1;
        ser_start   = 1'b0;
        rd_req_b    = 1'b0;
        rd_addr_b   = 1'b0;
        ser_start_b = 1'b0;
        rd_exp_q.push_back({1'b0, id_val[63:32]});
        repeat (3) @(negedge clk);
        checks++;
        if ({id_ready, id_fault, rd_ack, rd_err, ser_busy, ser_valid, ser_done, ser_data} !== 8'h00) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 00000000",
                     {id_ready, id_fault, rd_ack, rd_err, ser_busy, ser_valid, ser_done, ser_data});
        end
        checks++;
        if (rd_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_rd_data: got %h expected 00000000", rd_data);
        end
        checks++;
        if (mask_rev !== 32'h12345678) begin
            failures++;
            $display("FAIL reset_mask_rev: got %h expected 12345678", mask_rev);
        end
        checks++;
        if ({id_ready_b, rd_ack_b, ser_valid_b} !== 3'b000) begin
            failures++;
            $display("FAIL reset_b_flags: got %b expected 000", {id_ready_b, rd_ack_b, ser_valid_b});
        end
    endtask

    // Release reset: id_ready after 2 cycles, held request acked one cycle later.
    task automatic test_ready_stall();
        int          ready_cyc;
        bit          early_ack;
        logic [32:0] exp;
        ready_cyc = 0;
        early_ack = 1'b0;
        resetn = 1'b1;
        for (int c = 1; c <= 10 && ready_cyc == 0; c++) begin
            @(negedge clk);
            if (rd_ack === 1'b1) early_ack = 1'b1;
            if (id_ready === 1'b1) ready_cyc = c;
        end
        checks++;
        if (ready_cyc != 2) begin
            failures++;
            $display("FAIL ready_latency: got %0d expected 2", ready_cyc);
        end
        checks++;
        if (early_ack) begin
            failures++;
            $display("FAIL stall_before_ready: got ack=1 expected ack=0");
        end
        checks++;
        if (id_fault !== 1'b0) begin
            failures++;
            $display("FAIL ready_fault: got %b expected 0", id_fault);
        end
        @(negedge clk);
        checks++;
        if (rd_ack !== 1'b1) begin
            failures++;
            $display("FAIL held_req_ack: got %b expected 1", rd_ack);
        end
        exp = rd_exp_q.pop_front();
        checks++;
        if ({rd_err, rd_data} !== exp) begin
            failures++;
            $display("FAIL held_req_data: got %h expected %h", {rd_err, rd_data}, exp);
        end
        rd_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_word_read();
        logic [0:0] addrs [3];
        addrs[0] = 1'b0;
        addrs[1] = 1'b1;
        addrs[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            logic [32:0] exp;
            int          lat;
            rd_addr = addrs[i];
            rd_req  = 1'b1;
            rd_exp_q.push_back({1'b0, (addrs[i] == 1'b1) ? id_val[63:32] : id_val[31:0]});
            lat = 0;
            do begin
                @(negedge clk);
                lat++;
            end while (rd_ack !== 1'b1 && lat < 8);
            rd_req = 1'b0;
            checks++;
            if (lat != 1) begin
                failures++;
                $display("FAIL read_latency[%0d]: got %0d expected 1", i, lat);
            end
            exp = rd_exp_q.pop_front();
            checks++;
            if ({rd_err, rd_data} !== exp) begin
                failures++;
                $display("FAIL read_data[%0d]: got %h expected %h", i, {rd_err, rd_data}, exp);
            end
            repeat (2) @(negedge clk);
            checks++;
            if (rd_ack !== 1'b0 || rd_data !== exp[31:0]) begin
                failures++;
                $display("FAIL read_hold[%0d]: got ack=%b data=%h expected ack=0 data=%h",
                         i, rd_ack, rd_data, exp[31:0]);
            end
        end
    endtask

    // Request held continuously: acks land on every second cycle.
    task automatic test_back_to_back();
        int acks;
        bit prev;
        bit adjacent;
        acks = 0;
        prev = 1'b0;
        adjacent = 1'b0;
        rd_addr = 1'b1;
        rd_req  = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (rd_ack === 1'b1) begin
                if (prev) adjacent = 1'b1;
                acks++;
                checks++;
                if (rd_data !== id_val[63:32]) begin
                    failures++;
                    $display("FAIL b2b_data: got %h expected %h", rd_data, id_val[63:32]);
                end
            end
            prev = (rd_ack === 1'b1);
        end
        rd_req = 1'b0;
        checks++;
        if (acks != 4) begin
            failures++;
            $display("FAIL b2b_ack_count: got %0d expected 4", acks);
        end
        checks++;
        if (adjacent) begin
            failures++;
            $display("FAIL b2b_spacing: got adjacent acks expected none");
        end
        @(negedge clk);
        checks++;
        if (rd_ack !== 1'b0) begin
            failures++;
            $display("FAIL b2b_stray_ack: got %b expected 0", rd_ack);
        end
    endtask

    // Full serial readout with an ignored restart and a concurrent word read.
    task automatic test_serial();
        int   nvalid;
        logic exp;
        nvalid = 0;
        ser_start = 1'b1;
        for (int i = 63; i >= 0; i--) ser_exp_q.push_back(id_val[i]);
        @(negedge clk);
        ser_start = 1'b0;
        for (int k = 0; k < 70; k++) begin
            if (ser_valid === 1'b1) begin
                if (ser_exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL ser_extra_bit: got valid at cycle %0d expected idle", k);
                end else begin
                    exp = ser_exp_q.pop_front();
                    checks++;
                    if (ser_data !== exp) begin
                        failures++;
                        $display("FAIL ser_bit[%0d]: got %b expected %b", nvalid, ser_data, exp);
                    end
                    checks++;
                    if (ser_done !== (nvalid == 63) || ser_busy !== 1'b1) begin
                        failures++;
                        $display("FAIL ser_done_busy[%0d]: got done=%b busy=%b expected done=%b busy=1",
                                 nvalid, ser_done, ser_busy, (nvalid == 63));
                    end
                end
                nvalid++;
            end else begin
                checks++;
                if (ser_done !== 1'b0 || ser_busy !== 1'b0) begin
                    failures++;
                    $display("FAIL ser_idle[%0d]: got done=%b busy=%b expected 0 0", k, ser_done, ser_busy);
                end
            end
            if (rd_ack === 1'b1) begin
                logic [32:0] rexp;
                rexp = rd_exp_q.pop_front();
                rd_req = 1'b0;
                checks++;
                if ({rd_err, rd_data} !== rexp) begin
                    failures++;
                    $display("FAIL concurrent_read: got %h expected %h", {rd_err, rd_data}, rexp);
                end
            end
            if (k == 10) ser_start = 1'b1;
            if (k == 11) ser_start = 1'b0;
            if (k == 20) begin
                rd_addr = 1'b0;
                rd_req  = 1'b1;
                rd_exp_q.push_back({1'b0, id_val[31:0]});
            end
            @(negedge clk);
        end
        checks++;
        if (nvalid != 64) begin
            failures++;
            $display("FAIL ser_count: got %0d expected 64", nvalid);
        end
        checks++;
        if (rd_exp_q.size() != 0 || rd_req !== 1'b0) begin
            failures++;
            $display("FAIL concurrent_read_pending: got %0d outstanding expected 0", rd_exp_q.size());
        end
        rd_req = 1'b0;
        rd_exp_q.delete();
        ser_exp_q.delete();
    endtask

    // Reset in the middle of a serial shift and a pending read.
    task automatic test_reset_abort();
        bit          saw;
        int          ready_cyc;
        int          lat;
        logic [32:0] exp;
        ser_start = 1'b1;
        @(negedge clk);
        ser_start = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (ser_busy !== 1'b1) begin
            failures++;
            $display("FAIL abort_busy_before: got %b expected 1", ser_busy);
        end
        rd_addr = 1'b0;
        rd_req  = 1'b1;
        resetn  = 1'b0;
        @(negedge clk);
        checks++;
        if ({id_ready, id_fault, rd_ack, rd_err, ser_busy, ser_valid, ser_done, ser_data} !== 8'h00) begin
            failures++;
            $display("FAIL abort_flags: got %b expected 00000000",
                     {id_ready, id_fault, rd_ack, rd_err, ser_busy, ser_valid, ser_done, ser_data});
        end
        checks++;
        if (rd_data !== 32'h0) begin
            failures++;
            $display("FAIL abort_rd_data: got %h expected 00000000", rd_data);
        end
        saw = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (rd_ack !== 1'b0 || ser_done !== 1'b0 || ser_valid !== 1'b0) saw = 1'b1;
        end
        checks++;
        if (saw) begin
            failures++;
            $display("FAIL abort_quiet: got activity during reset expected none");
        end
        rd_exp_q.push_back({1'b0, id_val[31:0]});
        resetn = 1'b1;
        ready_cyc = 0;
        for (int c = 1; c <= 10 && ready_cyc == 0; c++) begin
            @(negedge clk);
            if (id_ready === 1'b1) ready_cyc = c;
        end
        checks++;
        if (ready_cyc != 2) begin
            failures++;
            $display("FAIL abort_ready_latency: got %0d expected 2", ready_cyc);
        end
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (rd_ack !== 1'b1 && lat < 8);
        rd_req = 1'b0;
        exp = rd_exp_q.pop_front();
        checks++;
        if (lat != 1 || {rd_err, rd_data} !== exp) begin
            failures++;
            $display("FAIL abort_reread: got lat=%0d data=%h expected lat=1 data=%h", lat, {rd_err, rd_data}, exp);
        end
        repeat (2) @(negedge clk);
    endtask

    // Live bit 5 differs between every CAPTURE and VERIFY.
    task automatic test_fault();
        int          ready_edges;
        logic [31:0] exp_lo;
        rd_req = 1'b0;
        resetn = 1'b0;
        force_val = id_val;
        force dut.live = force_val;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        ready_edges = 0;
        for (int c = 0; c < 20 && ready_edges == 0; c++) begin
            force_val = (c % 2 == 0) ? (id_val ^ 64'h20) : id_val;
            force dut.live = force_val;
            @(negedge clk);
            if (id_ready === 1'b1) ready_edges = c + 1;
        end
        release dut.live;
        checks++;
        if (ready_edges != 8) begin
            failures++;
            $display("FAIL fault_rounds: got %0d cycles expected 8", ready_edges);
        end
        checks++;
        if (id_fault !== 1'b1) begin
            failures++;
            $display("FAIL fault_flag: got %b expected 1", id_fault);
        end
        @(negedge clk);
        checks++;
        if (mask_rev !== 32'h12345678) begin
            failures++;
            $display("FAIL fault_mask_rev: got %h expected 12345678", mask_rev);
        end
        exp_lo = id_val[31:0] ^ 32'h20;
        rd_addr = 1'b0;
        rd_req  = 1'b1;
        rd_exp_q.push_back({1'b0, exp_lo});
        @(negedge clk);
        rd_req = 1'b0;
        begin
            logic [32:0] exp;
            exp = rd_exp_q.pop_front();
            checks++;
            if (rd_ack !== 1'b1 || {rd_err, rd_data} !== exp) begin
                failures++;
                $display("FAIL fault_read: got ack=%b data=%h expected ack=1 data=%h", rd_ack, {rd_err, rd_data}, exp);
            end
        end
        repeat (5) @(negedge clk);
        checks++;
        if (id_fault !== 1'b1 || id_ready !== 1'b1) begin
            failures++;
            $display("FAIL fault_sticky: got fault=%b ready=%b expected 1 1", id_fault, id_ready);
        end
        resetn = 1'b0;
        @(negedge clk);
        checks++;
        if (id_fault !== 1'b0) begin
            failures++;
            $display("FAIL fault_clear: got %b expected 0", id_fault);
        end
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (id_ready !== 1'b1 || id_fault !== 1'b0) begin
            failures++;
            $display("FAIL fault_recover: got ready=%b fault=%b expected 1 0", id_ready, id_fault);
        end
    endtask

    // 32-bit instance: single word, address 1 out of range, serial ends in a 1.
    task automatic test_width32();
        int   nvalid;
        logic exp;
        checks++;
        if (id_ready_b !== 1'b1 || id_fault_b !== 1'b0 || mask_rev_b !== 32'h1) begin
            failures++;
            $display("FAIL w32_status: got ready=%b fault=%b mask=%h expected 1 0 00000001",
                     id_ready_b, id_fault_b, mask_rev_b);
        end
        for (int i = 0; i < 2; i++) begin
            logic [32:0] rexp;
            int          lat;
            rd_addr_b = (i == 1) ? 1'b1 : 1'b0;
            rd_req_b  = 1'b1;
            rd_exp_q.push_back((i == 1) ? {1'b1, 32'h0} : {1'b0, id_b_val});
            lat = 0;
            do begin
                @(negedge clk);
                lat++;
            end while (rd_ack_b !== 1'b1 && lat < 8);
            rd_req_b = 1'b0;
            rexp = rd_exp_q.pop_front();
            checks++;
            if (lat != 1 || {rd_err_b, rd_data_b} !== rexp) begin
                failures++;
                $display("FAIL w32_read[%0d]: got lat=%0d data=%h expected lat=1 data=%h",
                         i, lat, {rd_err_b, rd_data_b}, rexp);
            end
            @(negedge clk);
        end
        nvalid = 0;
        ser_start_b = 1'b1;
        for (int i = 31; i >= 0; i--) ser_exp_q.push_back(id_b_val[i]);
        @(negedge clk);
        ser_start_b = 1'b0;
        for (int k = 0; k < 36; k++) begin
            if (ser_valid_b === 1'b1) begin
                if (ser_exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL w32_ser_extra: got valid at cycle %0d expected idle", k);
                end else begin
                    exp = ser_exp_q.pop_front();
                    checks++;
                    if (ser_data_b !== exp || ser_done_b !== (nvalid == 31) || ser_busy_b !== 1'b1) begin
                        failures++;
                        $display("FAIL w32_ser[%0d]: got bit=%b done=%b busy=%b expected bit=%b done=%b busy=1",
                                 nvalid, ser_data_b, ser_done_b, ser_busy_b, exp, (nvalid == 31));
                    end
                end
                nvalid++;
            end
            @(negedge clk);
        end
        checks++;
        if (nvalid != 32 || ser_busy_b !== 1'b0) begin
            failures++;
            $display("FAIL w32_ser_count: got %0d busy=%b expected 32 busy=0", nvalid, ser_busy_b);
        end
        ser_exp_q.delete();
    endtask

    initial begin
        id_val    = ID_A;
        id_b_val  = ID_B;
        force_val = '0;
        test_reset();
        test_ready_stall();
        test_word_read();
        test_back_to_back();
        test_serial();
        test_reset_abort();
        test_fault();
        test_width32();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
